// File: rtl/char_buffer_controller.sv
// Command-driven writer for the character buffer and scroll origin used by char_generator.
// Turns put-char / CR / LF / clear / goto commands into buffer writes and origin updates,
// tracks the cursor, and scrolls by advancing the circular-buffer origin.
module char_buffer_controller #(
    parameter int unsigned ROWS      = 24,
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROW_BITS  = 5,
    parameter int unsigned COL_BITS  = 7,
    parameter int unsigned ADDR_BITS = 11,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [7:0]           cmd_data,
    input  logic [ROW_BITS-1:0]  cmd_row,
    input  logic [COL_BITS-1:0]  cmd_col,
    output logic [ADDR_BITS-1:0] buffer_waddr,
    output logic [7:0]           buffer_din,
    output logic                 buffer_wen,
    output logic [ADDR_BITS-1:0] buffer_first_char,
    output logic                 buffer_first_char_wen,
    output logic [ROW_BITS-1:0]  cursor_row,
    output logic [COL_BITS-1:0]  cursor_col,
    output logic                 busy
);

    localparam int unsigned BUF_SIZE = ROWS * COLS;

    localparam logic [2:0] OP_PUTC  = 3'd1;
    localparam logic [2:0] OP_CR    = 3'd2;
    localparam logic [2:0] OP_LF    = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;
    localparam logic [2:0] OP_GOTO  = 3'd5;

    typedef enum logic [1:0] {IDLE, FILL, SEEK, WRAP} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] first_char;
    logic [ADDR_BITS-1:0] line_addr;
    logic [ADDR_BITS-1:0] fill_addr;
    logic [ADDR_BITS-1:0] cnt;

    logic                 accept;
    logic                 scroll_now;
    logic [ADDR_BITS-1:0] cell_addr;
    logic [ROW_BITS-1:0]  row_tgt;
    logic [COL_BITS-1:0]  col_tgt;

    // Modular add for operands below BUF_SIZE and a step of at most COLS.
    function automatic logic [ADDR_BITS-1:0] wrap_add(input logic [ADDR_BITS-1:0] a,
                                                       input logic [ADDR_BITS-1:0] b);
        logic [ADDR_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (ADDR_BITS+1)'(BUF_SIZE))
            s = s - (ADDR_BITS+1)'(BUF_SIZE);
        return s[ADDR_BITS-1:0];
    endfunction

    // Command decode helpers: acceptance, scroll trigger, cell address and clamped goto target.
    always_comb begin
        accept     = cmd_valid && cmd_ready && (state == IDLE);
        scroll_now = (state == WRAP) ||
                     (accept && (cmd_op == OP_LF) && (cursor_row == ROW_BITS'(ROWS-1)));
        cell_addr  = wrap_add(line_addr, ADDR_BITS'(cursor_col));
        row_tgt    = (cmd_row > ROW_BITS'(ROWS-1)) ? ROW_BITS'(ROWS-1) : cmd_row;
        col_tgt    = (cmd_col > COL_BITS'(COLS-1)) ? COL_BITS'(COLS-1) : cmd_col;
    end

    // Controller state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state                 <= IDLE;
            first_char            <= '0;
            line_addr             <= '0;
            fill_addr             <= '0;
            cnt                   <= '0;
            cmd_ready             <= 1'b0;
            buffer_waddr          <= '0;
            buffer_din            <= '0;
            buffer_wen            <= 1'b0;
            buffer_first_char     <= '0;
            buffer_first_char_wen <= 1'b0;
            cursor_row            <= '0;
            cursor_col            <= '0;
            busy                  <= 1'b0;
        end else begin
            buffer_wen            <= 1'b0;
            buffer_first_char_wen <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (accept) begin
                        case (cmd_op)
                            OP_PUTC: begin
                                buffer_wen   <= 1'b1;
                                buffer_waddr <= cell_addr;
                                buffer_din   <= cmd_data;
                                if (cursor_col < COL_BITS'(COLS-1)) begin
                                    cursor_col <= cursor_col + COL_BITS'(1);
                                end else begin
                                    cursor_col <= '0;
                                    if (cursor_row < ROW_BITS'(ROWS-1)) begin
                                        cursor_row <= cursor_row + ROW_BITS'(1);
                                        line_addr  <= wrap_add(line_addr, ADDR_BITS'(COLS));
                                    end else begin
                                        // Park one cycle so the char write and fill never share the port.
                                        state     <= WRAP;
                                        cmd_ready <= 1'b0;
                                        busy      <= 1'b1;
                                    end
                                end
                            end
                            OP_CR: cursor_col <= '0;
                            OP_LF: begin
                                if (cursor_row < ROW_BITS'(ROWS-1)) begin
                                    cursor_row <= cursor_row + ROW_BITS'(1);
                                    line_addr  <= wrap_add(line_addr, ADDR_BITS'(COLS));
                                end
                            end
                            OP_CLEAR: begin
                                first_char            <= '0;
                                buffer_first_char     <= '0;
                                buffer_first_char_wen <= 1'b1;
                                line_addr             <= '0;
                                cursor_row            <= '0;
                                cursor_col            <= '0;
                                buffer_wen            <= 1'b1;
                                buffer_waddr          <= '0;
                                buffer_din            <= FILL_CHAR;
                                fill_addr             <= ADDR_BITS'(1);
                                cnt                   <= ADDR_BITS'(BUF_SIZE-1);
                                state                 <= FILL;
                                cmd_ready             <= 1'b0;
                                busy                  <= 1'b1;
                            end
                            OP_GOTO: begin
                                cursor_row <= row_tgt;
                                cursor_col <= col_tgt;
                                line_addr  <= first_char;
                                if (row_tgt != '0) begin
                                    cnt       <= ADDR_BITS'(row_tgt);
                                    state     <= SEEK;
                                    cmd_ready <= 1'b0;
                                    busy      <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                FILL: begin
                    if (cnt != '0) begin
                        buffer_wen   <= 1'b1;
                        buffer_waddr <= fill_addr;
                        buffer_din   <= FILL_CHAR;
                        fill_addr    <= wrap_add(fill_addr, ADDR_BITS'(1));
                        cnt          <= cnt - ADDR_BITS'(1);
                    end else begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                SEEK: begin
                    line_addr <= wrap_add(line_addr, ADDR_BITS'(COLS));
                    cnt       <= cnt - ADDR_BITS'(1);
                    if (cnt == ADDR_BITS'(1)) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase

            // Scroll: old origin becomes the bottom line, origin advances one row, bottom line is blanked.
            if (scroll_now) begin
                line_addr             <= first_char;
                first_char            <= wrap_add(first_char, ADDR_BITS'(COLS));
                buffer_first_char     <= wrap_add(first_char, ADDR_BITS'(COLS));
                buffer_first_char_wen <= 1'b1;
                buffer_wen            <= 1'b1;
                buffer_waddr          <= first_char;
                buffer_din            <= FILL_CHAR;
                fill_addr             <= wrap_add(first_char, ADDR_BITS'(1));
                cnt                   <= ADDR_BITS'(COLS-1);
                state                 <= FILL;
                cmd_ready             <= 1'b0;
                busy                  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_char_buffer_controller.sv
// Directed bench for char_buffer_controller: outputs sampled on the falling edge.
module tb_char_buffer_controller;

    logic        clk = 1'b0;
    logic        clr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [4:0]  cmd_row;
    logic [6:0]  cmd_col;
    logic [10:0] buffer_waddr;
    logic [7:0]  buffer_din;
    logic        buffer_wen;
    logic [10:0] buffer_first_char;
    logic        buffer_first_char_wen;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    int errors = 0;
    int checks = 0;

    char_buffer_controller dut (
        .clk                   (clk),
        .clr                   (clr),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_op                (cmd_op),
        .cmd_data              (cmd_data),
        .cmd_row               (cmd_row),
        .cmd_col               (cmd_col),
        .buffer_waddr          (buffer_waddr),
        .buffer_din            (buffer_din),
        .buffer_wen            (buffer_wen),
        .buffer_first_char     (buffer_first_char),
        .buffer_first_char_wen (buffer_first_char_wen),
        .cursor_row            (cursor_row),
        .cursor_col            (cursor_col),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for ready, present one command for one edge, return observing the cycle after.
    task automatic issue(input logic [2:0] op, input logic [7:0] data,
                         input logic [4:0] row, input logic [6:0] col);
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            tick();
            n++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_row   = row;
        cmd_col   = col;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    // Count cycles with ready low, starting at the current observation.
    task automatic seek_wait(input string tag, input int exp);
        int n = 0;
        while (!cmd_ready && n < 100) begin
            n++;
            tick();
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    // Follow a fill from the current observation until ready returns; optionally hold a junk command.
    task automatic run_fill(input string tag, input int start, input int count, input bit junk);
        int          low = 0;
        int          nw  = 0;
        int          bad = 0;
        logic [10:0] a;
        a = 11'(start);
        if (junk) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'd1;
            cmd_data  = 8'h58;
        end
        while (!cmd_ready && low < 4000) begin
            if (buffer_wen) begin
                if (buffer_waddr !== a || buffer_din !== 8'h20) bad++;
                nw++;
                a = (a == 11'd1919) ? 11'd0 : a + 11'd1;
            end
            low++;
            tick();
        end
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        chk({tag, "_low_cycles"}, 32'(low), 32'(count));
        chk({tag, "_writes"}, 32'(nw), 32'(count));
        chk({tag, "_bad_writes"}, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 8'h00;
        cmd_row   = 5'd0;
        cmd_col   = 7'd0;
        tick();
        tick();
        chk("rst_wen", 32'(buffer_wen), 32'd0);
        chk("rst_waddr", 32'(buffer_waddr), 32'd0);
        chk("rst_din", 32'(buffer_din), 32'd0);
        chk("rst_fc_wen", 32'(buffer_first_char_wen), 32'd0);
        chk("rst_fc", 32'(buffer_first_char), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        clr = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // PUTC 'A' at origin
        issue(3'd1, 8'h41, 5'd0, 7'd0);
        chk("putA_wen", 32'(buffer_wen), 32'd1);
        chk("putA_waddr", 32'(buffer_waddr), 32'd0);
        chk("putA_din", 32'(buffer_din), 32'h41);
        chk("putA_col", 32'(cursor_col), 32'd1);
        chk("putA_row", 32'(cursor_row), 32'd0);
        chk("putA_ready", 32'(cmd_ready), 32'd1);

        // GOTO bottom-right, then PUTC wraps and scrolls
        issue(3'd5, 8'h00, 5'd23, 7'd79);
        chk("goto_row", 32'(cursor_row), 32'd23);
        chk("goto_col", 32'(cursor_col), 32'd79);
        chk("goto_busy", 32'(busy), 32'd1);
        seek_wait("goto23_seek", 23);
        issue(3'd1, 8'h5A, 5'd0, 7'd0);
        chk("putZ_wen", 32'(buffer_wen), 32'd1);
        chk("putZ_waddr", 32'(buffer_waddr), 32'd1919);
        chk("putZ_din", 32'(buffer_din), 32'h5A);
        chk("putZ_fc_wen_early", 32'(buffer_first_char_wen), 32'd0);
        chk("putZ_row", 32'(cursor_row), 32'd23);
        chk("putZ_col", 32'(cursor_col), 32'd0);
        chk("putZ_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("putZ_fc_wen", 32'(buffer_first_char_wen), 32'd1);
        chk("putZ_fc", 32'(buffer_first_char), 32'd80);
        run_fill("putZ_fill", 0, 80, 1'b0);

        // 23 scrolls from reset, then seek, CR/LF, NOP, clamp and the wrapping 24th scroll
        do_reset();
        issue(3'd5, 8'h00, 5'd23, 7'd0);
        seek_wait("goto23b_seek", 23);
        for (int i = 1; i <= 23; i++) begin
            issue(3'd3, 8'h00, 5'd0, 7'd0);
            chk("lf_fc_wen", 32'(buffer_first_char_wen), 32'd1);
            chk("lf_fc", 32'(buffer_first_char), 32'(80 * i));
            run_fill("lf_fill", 80 * (i - 1), 80, 1'b0);
        end
        chk("scroll_row", 32'(cursor_row), 32'd23);
        issue(3'd5, 8'h00, 5'd1, 7'd5);
        seek_wait("goto1_seek", 1);
        issue(3'd1, 8'h71, 5'd0, 7'd0);
        chk("putq_waddr", 32'(buffer_waddr), 32'd5);
        chk("putq_din", 32'(buffer_din), 32'h71);
        chk("putq_col", 32'(cursor_col), 32'd6);
        issue(3'd2, 8'h00, 5'd0, 7'd0);
        chk("cr_col", 32'(cursor_col), 32'd0);
        chk("cr_wen", 32'(buffer_wen), 32'd0);
        issue(3'd3, 8'h00, 5'd0, 7'd0);
        chk("lf_row", 32'(cursor_row), 32'd2);
        chk("lf_fc_wen_none", 32'(buffer_first_char_wen), 32'd0);
        chk("lf_ready", 32'(cmd_ready), 32'd1);
        issue(3'd1, 8'h62, 5'd0, 7'd0);
        chk("putb_waddr", 32'(buffer_waddr), 32'd80);
        issue(3'd6, 8'h63, 5'd9, 7'd9);
        chk("nop_wen", 32'(buffer_wen), 32'd0);
        chk("nop_col", 32'(cursor_col), 32'd1);
        chk("nop_row", 32'(cursor_row), 32'd2);
        chk("nop_ready", 32'(cmd_ready), 32'd1);
        issue(3'd5, 8'h00, 5'd30, 7'd100);
        chk("clamp_row", 32'(cursor_row), 32'd23);
        chk("clamp_col", 32'(cursor_col), 32'd79);
        seek_wait("clamp_seek", 23);
        issue(3'd3, 8'h00, 5'd0, 7'd0);
        chk("lf24_fc_wen", 32'(buffer_first_char_wen), 32'd1);
        chk("lf24_fc", 32'(buffer_first_char), 32'd0);
        run_fill("lf24_fill", 1840, 80, 1'b0);

        // CLEAR with a command held during the fill
        issue(3'd4, 8'h00, 5'd0, 7'd0);
        chk("clr_fc_wen", 32'(buffer_first_char_wen), 32'd1);
        chk("clr_fc", 32'(buffer_first_char), 32'd0);
        chk("clr_row", 32'(cursor_row), 32'd0);
        chk("clr_col", 32'(cursor_col), 32'd0);
        run_fill("clear_fill", 0, 1920, 1'b1);
        chk("clr_after_wen", 32'(buffer_wen), 32'd0);

        // Reset in the middle of a CLEAR fill
        issue(3'd4, 8'h00, 5'd0, 7'd0);
        repeat (39) tick();
        chk("midfill_wen", 32'(buffer_wen), 32'd1);
        chk("midfill_waddr", 32'(buffer_waddr), 32'd39);
        clr = 1'b1;
        tick();
        chk("abort_wen", 32'(buffer_wen), 32'd0);
        chk("abort_waddr", 32'(buffer_waddr), 32'd0);
        chk("abort_din", 32'(buffer_din), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        chk("abort_fc", 32'(buffer_first_char), 32'd0);
        clr = 1'b0;
        tick();
        chk("abort_ready_after", 32'(cmd_ready), 32'd1);
        chk("abort_wen_after", 32'(buffer_wen), 32'd0);
        chk("abort_busy_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
